// File: rtl/sel_encode_sb.sv
// Select-and-encode stage: owns the instruction register, decodes the Gra/Grb/Grc field into one-hot
// register enables, and keeps a write scoreboard. Optional macro R0_ZERO_EN makes R0 a constant-zero base.
module sel_encode_sb #(
  parameter int IW     = 32,
  parameter int NREG   = 16,
  parameter int RIDX_W = 4,
  parameter int OPC_W  = 5,
  parameter int RA_LSB = 23,
  parameter int RB_LSB = 19,
  parameter int RC_LSB = 15,
  parameter int IMM_W  = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ir_load,
  input  logic [IW-1:0]     ir_d,
  input  logic              gra,
  input  logic              grb,
  input  logic              grc,
  input  logic              rin,
  input  logic              rout,
  input  logic              ba_out,
  input  logic              issue,
  input  logic              wb_valid,
  input  logic [RIDX_W-1:0] wb_idx,
  output logic [IW-1:0]     ir_q,
  output logic [OPC_W-1:0]  opcode,
  output logic [IW-1:0]     c_sext,
  output logic [NREG-1:0]   reg_in,
  output logic [NREG-1:0]   reg_out,
  output logic              sel_err,
  output logic              hazard,
  output logic [NREG-1:0]   pending
);

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic [RIDX_W-1:0] ra, rb, rc, sel;
  logic              any_sel, rd_en;
  logic [NREG-1:0]   sel_hot, set_vec, clr_vec;
  logic              pend_rb, pend_rc;

  assign ra = ir_q[RA_LSB +: RIDX_W];
  assign rb = ir_q[RB_LSB +: RIDX_W];
  assign rc = ir_q[RC_LSB +: RIDX_W];

  assign opcode = ir_q[IW-1 -: OPC_W];
  assign c_sext = {{(IW-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

  // Priority select: Gra beats Grb beats Grc even when several strobes collide.
  always_comb begin
    sel = ra;
    if (gra)      sel = ra;
    else if (grb) sel = rb;
    else if (grc) sel = rc;
  end

  assign any_sel = gra | grb | grc;
  assign sel_err = (gra & grb) | (gra & grc) | (grb & grc);
  assign sel_hot = any_sel ? (ONE << sel) : '0;

`ifdef R0_ZERO_EN
  // A base-address read of R0 yields zero on the bus, so R0 is not enabled for it.
  assign rd_en   = rout | (ba_out & (sel != '0));
  assign pend_rb = pending[rb] & (rb != '0);
  assign pend_rc = pending[rc] & (rc != '0);
  assign set_vec = (issue && !hazard && (ra != '0)) ? (ONE << ra) : '0;
`else
  assign rd_en   = rout | ba_out;
  assign pend_rb = pending[rb];
  assign pend_rc = pending[rc];
  assign set_vec = (issue && !hazard) ? (ONE << ra) : '0;
`endif

  assign reg_in  = sel_hot & {NREG{rin}};
  assign reg_out = sel_hot & {NREG{rd_en}};
  assign hazard  = pend_rb | pend_rc;
  assign clr_vec = wb_valid ? (ONE << wb_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= '0;
    end else if (ir_load) begin
      ir_q <= ir_d;
    end
  end

  // Set is applied after clear so an issue and a writeback to the same register leave it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

endmodule

// File: tb/tb_sel_encode_sb.sv
// Directed scoreboard bench for sel_encode_sb; expectations adapt to R0_ZERO_EN when defined.
module tb_sel_encode_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ir_load;
  logic [31:0] ir_d;
  logic        gra, grb, grc, rin, rout, ba_out, issue, wb_valid;
  logic [3:0]  wb_idx;
  logic [31:0] ir_q;
  logic [4:0]  opcode;
  logic [31:0] c_sext;
  logic [15:0] reg_in, reg_out, pending;
  logic        sel_err, hazard;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  sel_encode_sb dut (
    .clk(clk), .rst_n(rst_n), .ir_load(ir_load), .ir_d(ir_d),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .ba_out(ba_out),
    .issue(issue), .wb_valid(wb_valid), .wb_idx(wb_idx),
    .ir_q(ir_q), .opcode(opcode), .c_sext(c_sext), .reg_in(reg_in), .reg_out(reg_out),
    .sel_err(sel_err), .hazard(hazard), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [18:0] c);
    return {opc, ra, rb, c};
  endfunction

  task automatic applyStimulus(input logic ld, input logic [31:0] d, input logic a, input logic b,
                               input logic c, input logic ri, input logic ro, input logic ba,
                               input logic is, input logic wv, input logic [3:0] wi);
    ir_load = ld; ir_d = d; gra = a; grb = b; grc = c; rin = ri; rout = ro; ba_out = ba;
    issue = is; wb_valid = wv; wb_idx = wi;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExpected(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag = tag;
    e.value = value;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $error("[TB] FAIL scoreboard_empty: observed %h required an expectation", observed);
    end else begin
      e = sb_q.pop_front();
      assert (observed === e.value) else begin
        fails++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, observed, e.value);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    pushExpected("rst_ir_q", 32'h0);      checkOutput(ir_q);
    pushExpected("rst_pending", 32'h0);   checkOutput({16'h0, pending});
    pushExpected("rst_opcode", 32'h0);    checkOutput({27'h0, opcode});
    pushExpected("rst_c_sext", 32'h0);    checkOutput(c_sext);
    pushExpected("rst_hazard", 32'h0);    checkOutput({31'h0, hazard});
    pushExpected("rst_sel_err", 32'h0);   checkOutput({31'h0, sel_err});
    rst_n = 1'b1;

    // Ra=4, Rb=3, Rc=5, opcode=1, C=19'h28000
    applyStimulus(1, 32'h0A1A_8000, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    pushExpected("ir_load", 32'h0A1A_8000);  checkOutput(ir_q);
    pushExpected("opcode_1", 32'd1);         checkOutput({27'h0, opcode});
    pushExpected("c_sext_pos", 32'h0002_8000); checkOutput(c_sext);

    applyStimulus(0, '0, 0, 0, 0, 1, 0, 0, 0, 0, 4'd0);
    pushExpected("no_strobe_reg_in", 32'h0); checkOutput({16'h0, reg_in});
    applyStimulus(0, '0, 1, 0, 0, 1, 0, 0, 0, 0, 4'd0);
    pushExpected("gra_rin_reg_in", 32'h0010);  checkOutput({16'h0, reg_in});
    pushExpected("gra_rin_reg_out", 32'h0);    checkOutput({16'h0, reg_out});
    applyStimulus(0, '0, 0, 0, 1, 0, 1, 0, 0, 0, 4'd0);
    pushExpected("grc_rout_reg_out", 32'h0020); checkOutput({16'h0, reg_out});
    pushExpected("grc_rout_reg_in", 32'h0);     checkOutput({16'h0, reg_in});
    applyStimulus(0, '0, 1, 1, 0, 1, 0, 0, 0, 0, 4'd0);
    pushExpected("gra_grb_sel_err", 32'h1);     checkOutput({31'h0, sel_err});
    pushExpected("gra_grb_reg_in", 32'h0010);   checkOutput({16'h0, reg_in});
    applyStimulus(0, '0, 0, 1, 1, 0, 1, 0, 0, 0, 4'd0);
    pushExpected("grb_grc_reg_out", 32'h0008);  checkOutput({16'h0, reg_out});

    // Issue Ra=4; IR Rb=3/Rc=5 sees no hazard
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    pushExpected("issue_ra4", 32'h0010);        checkOutput({16'h0, pending});
    pushExpected("no_hazard", 32'h0);           checkOutput({31'h0, hazard});

    // Rb=4 -> hazard; Ra=6, Rc=8, C negative
    applyStimulus(1, mk(5'd2, 4'd6, 4'd4, 19'h40000), 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    pushExpected("hazard_rb4", 32'h1);          checkOutput({31'h0, hazard});
    pushExpected("opcode_2", 32'd2);            checkOutput({27'h0, opcode});
    pushExpected("c_sext_neg", 32'hFFFC_0000);  checkOutput(c_sext);

    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    pushExpected("issue_in_hazard", 32'h0010);  checkOutput({16'h0, pending});

    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd4);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    pushExpected("wb_clears_hazard", 32'h0);    checkOutput({31'h0, hazard});
    pushExpected("wb_clears_pending", 32'h0);   checkOutput({16'h0, pending});

    // Ra=7, Rb=0, Rc=7, C=19'h3FFFF
    applyStimulus(1, mk(5'd3, 4'd7, 4'd0, 19'h3FFFF), 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    pushExpected("c_sext_max_pos", 32'h0003_FFFF); checkOutput(c_sext);
    applyStimulus(0, '0, 0, 1, 0, 0, 0, 1, 0, 0, 4'd0);
`ifdef R0_ZERO_EN
    pushExpected("grb_ba_r0", 32'h0);
`else
    pushExpected("grb_ba_r0", 32'h0001);
`endif
    checkOutput({16'h0, reg_out});

    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 1, 1, 4'd7);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    pushExpected("set_clear_collide", 32'h0080); checkOutput({16'h0, pending});
    pushExpected("hazard_rc7", 32'h1);           checkOutput({31'h0, hazard});

    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd7);
    tick();
    // Load and issue together: the outgoing IR's Ra=7 is marked
    applyStimulus(1, mk(5'd1, 4'd0, 4'd2, 19'h0), 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    pushExpected("load_issue_pre_ir", 32'h0080); checkOutput({16'h0, pending});
    pushExpected("load_issue_new_ir", mk(5'd1, 4'd0, 4'd2, 19'h0)); checkOutput(ir_q);

    applyStimulus(0, '0, 0, 0, 1, 0, 1, 0, 0, 0, 4'd0);
    pushExpected("grc_rout_r0", 32'h0001);      checkOutput({16'h0, reg_out});
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
`ifdef R0_ZERO_EN
    pushExpected("issue_r0", 32'h0080);
    pushExpected("hazard_r0", 32'h0);
`else
    pushExpected("issue_r0", 32'h0081);
    pushExpected("hazard_r0", 32'h1);
`endif
    checkOutput({16'h0, pending});
    checkOutput({31'h0, hazard});

    // Build pending=16'h00F0 then reset asynchronously mid-cycle
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd7);
    tick();
    for (int r = 4; r < 8; r++) begin
      applyStimulus(1, mk(5'd0, 4'(r), 4'd1, 19'h0), 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
      tick();
      applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
      tick();
    end
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    pushExpected("pending_f0", 32'h00F0);       checkOutput({16'h0, pending});
    #1 rst_n = 1'b0;
    #1;
    pushExpected("async_rst_pending", 32'h0);   checkOutput({16'h0, pending});
    pushExpected("async_rst_ir_q", 32'h0);      checkOutput(ir_q);
    tick();
    rst_n = 1'b1;
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd5);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    pushExpected("stale_wb", 32'h0);            checkOutput({16'h0, pending});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
